// File: rtl/dmem_responder.sv
// Byte-addressable RV32I data memory responder with width/sign handling and error checks.
// Latency: response strobe LATENCY+1 cycles after the accepting edge; one request per LATENCY+2 cycles.
// Backpressure: req_ready only in IDLE; no response backpressure (resp_valid is a one-cycle strobe).
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic        cap_we;
    logic [2:0]  cap_func3;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        enter_resp;
    logic        cur_we;
    logic [2:0]  cur_func3;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [AW-1:0] cur_idx;
    logic        f3_legal, misalign, out_of_range, cur_err;
    logic [3:0]  byte_mask;
    logic [31:0] wdata_rep;
    logic [31:0] mem_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic        mem_we;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign accept     = req_ready && req_valid;
    assign enter_resp = (accept && (LATENCY == 0)) || (state_q == WAIT && cnt_q == 4'd0);

    // With zero latency the request is serviced on the accepting edge, straight from the ports.
    assign cur_we    = req_ready ? req_we    : cap_we;
    assign cur_func3 = req_ready ? req_func3 : cap_func3;
    assign cur_addr  = req_ready ? req_addr  : cap_addr;
    assign cur_wdata = req_ready ? req_wdata : cap_wdata;
    assign cur_idx   = cur_addr[AW+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 4'd0;
            cap_we    <= 1'b0;
            cap_func3 <= 3'd0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
        end else if (accept) begin
            cnt_q     <= LAT_M1;
            cap_we    <= req_we;
            cap_func3 <= req_func3;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
        end else if (state_q == WAIT && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    always_comb begin
        f3_legal = 1'b0;
        if (cur_we) begin
            f3_legal = (cur_func3 == 3'b000) || (cur_func3 == 3'b001) || (cur_func3 == 3'b010);
        end else begin
            f3_legal = (cur_func3 == 3'b000) || (cur_func3 == 3'b001) || (cur_func3 == 3'b010) ||
                       (cur_func3 == 3'b100) || (cur_func3 == 3'b101);
        end
    end

    assign misalign     = ((cur_func3[1:0] == 2'b01) && cur_addr[0]) ||
                          ((cur_func3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
    assign out_of_range = {2'b00, cur_addr[31:2]} >= 32'(DEPTH);
    assign cur_err      = !f3_legal || misalign || out_of_range;

    always_comb begin
        byte_mask = 4'b0000;
        wdata_rep = cur_wdata;
        case (cur_func3[1:0])
            2'b00: begin
                byte_mask = 4'b0001 << cur_addr[1:0];
                wdata_rep = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                byte_mask = 4'b0011 << cur_addr[1:0];
                wdata_rep = {2{cur_wdata[15:0]}};
            end
            default: byte_mask = 4'b1111;
        endcase
    end

    assign mem_we = enter_resp && cur_we && !cur_err && !rst;

    // Storage has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && byte_mask[i]) begin
                mem[cur_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    assign mem_word = mem[cur_idx];
    assign ld_byte  = mem_word[{cur_addr[1:0], 3'b000} +: 8];
    assign ld_half  = mem_word[{cur_addr[1], 4'b0000} +: 16];

    always_comb begin
        ld_val = mem_word;
        case (cur_func3)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = mem_word;
        endcase
    end

    // Response registers are loaded only on entry to RESP, so they read zero everywhere else.
    always_ff @(posedge clk) begin
        if (rst || !enter_resp) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            resp_err   <= cur_err;
            resp_rdata <= (cur_err || cur_we) ? 32'd0 : ld_val;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: LATENCY=2 instance for function/errors/reset, LATENCY=0 instance for throughput.
module tb_dmem_responder;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_func3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        z_req_valid = 1'b0;
    logic        z_req_ready;
    logic        z_resp_valid;
    logic [31:0] z_resp_rdata;
    logic        z_resp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_we(1'b1), .req_func3(3'b010), .req_addr(32'h4), .req_wdata(32'h0BAD_F00D),
        .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        @(negedge clk);
        req_we = we; req_func3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        chk({tag, "_rdata"}, resp_rdata, exp_rd);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_z_ready", {31'd0, z_req_ready}, 32'd1);

        txn("sw10", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0);
        txn("lw10", 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0);
        txn("sb11", 1'b1, 3'b000, 32'h11, 32'h0000_0055, 32'd0, 1'b0);
        txn("lw10b", 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEAD_55EF, 1'b0);
        txn("lb13", 1'b0, 3'b000, 32'h13, 32'd0, 32'hFFFF_FFDE, 1'b0);
        txn("lbu13", 1'b0, 3'b100, 32'h13, 32'd0, 32'h0000_00DE, 1'b0);
        txn("lhu12", 1'b0, 3'b101, 32'h12, 32'd0, 32'h0000_DEAD, 1'b0);
        txn("lh12", 1'b0, 3'b001, 32'h12, 32'd0, 32'hFFFF_DEAD, 1'b0);
        txn("lh10", 1'b0, 3'b001, 32'h10, 32'd0, 32'h0000_55EF, 1'b0);
        txn("lb11", 1'b0, 3'b000, 32'h11, 32'd0, 32'h0000_0055, 1'b0);

        txn("sh13", 1'b1, 3'b001, 32'h13, 32'h0000_1234, 32'd0, 1'b1);
        txn("lw12", 1'b0, 3'b010, 32'h12, 32'd0, 32'd0, 1'b1);
        txn("ld011", 1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 1'b1);
        txn("st100", 1'b1, 3'b100, 32'h10, 32'h1111_1111, 32'd0, 1'b1);
        txn("sw_oor", 1'b1, 3'b010, DEPTH * 4, 32'h2222_2222, 32'd0, 1'b1);
        txn("lw10c", 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEAD_55EF, 1'b0);

        txn("lw_oor", 1'b0, 3'b010, DEPTH * 4, 32'd0, 32'd0, 1'b1);
        txn("sw_last", 1'b1, 3'b010, (DEPTH - 1) * 4, 32'hA5A5_1234, 32'd0, 1'b0);
        txn("lw_last", 1'b0, 3'b010, (DEPTH - 1) * 4, 32'd0, 32'hA5A5_1234, 1'b0);

        txn("sw20", 1'b1, 3'b010, 32'h20, 32'h1111_2222, 32'd0, 1'b0);
        @(negedge clk);
        req_we = 1'b1; req_func3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h9999_9999;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_in_wait", {31'd0, req_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid) seen++;
            @(negedge clk);
        end
        chk("abort_no_resp", 32'(seen), 32'd0);
        txn("lw20", 1'b0, 3'b010, 32'h20, 32'd0, 32'h1111_2222, 1'b0);

        // Zero-latency instance with req_valid held high: IDLE and RESP alternate.
        @(negedge clk);
        z_req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("z_ready_%0d", i), {31'd0, z_req_ready}, {31'd0, ~i[0]});
            chk($sformatf("z_valid_%0d", i), {31'd0, z_resp_valid}, {31'd0, i[0]});
            chk($sformatf("z_err_%0d", i), {31'd0, z_resp_err}, 32'd0);
            @(negedge clk);
        end
        z_req_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
